nios_hps_system_i2c_byte_engine: RTL and testbench

Avalon-MM slave that runs I2C master transfers in hardware: START, one 8-bit write or read with an ACK bit, and STOP. It replaces the software bit-banged SCL GPIO path on the Nios side. The Nios issues a byte-level command, polls STATUS, and the block drives the open-drain SCL/SDA pad enables directly.

---
 rtl/nios_hps_system_i2c_byte_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_nios_hps_system_i2c_byte_engine.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_hps_system_i2c_byte_engine.sv
// nios_hps_system_i2c_byte_engine
//
// Avalon-MM slave that runs one I2C master byte transfer in hardware:
// an optional START, an optional 8-bit WRITE or READ with its ACK slot, and
// an optional STOP. The Nios writes a command, polls STATUS, and the block
// drives the open-drain SCL/SDA pad enables directly.
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   address     register select (0 TXRX, 1 CMD, 2 STATUS, 3 DIV)
//   chipselect  slave select; a write is chipselect=1 with write_n=0
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    read data, combinational from address (latency 0)
//   scl_in      SCL pad level
//   sda_in      SDA pad level
//   scl_oe      1 pulls SCL low, 0 releases it
//   sda_oe      1 pulls SDA low, 0 releases it
//
// Optional feature: define I2C_CLK_STRETCH_EN to let a slave stretch the
// clock. While SCL is released by the master and the pad still reads low,
// the quarter counter holds. Without the macro scl_in is ignored.
module nios_hps_system_i2c_byte_engine #(
  parameter logic [15:0] DIV_DEFAULT = 16'd124
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_ACK,
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  state_t      w_afterStart;
  state_t      w_afterAck;

  logic [7:0]  r_txByte;
  logic [7:0]  r_rxByte;
  logic [7:0]  r_shift;
  logic [15:0] r_div;
  logic [15:0] r_cnt;
  logic [1:0]  r_q;
  logic [2:0]  r_bit;
  logic        r_cmdErr;
  logic        r_rxNack;
  logic        r_doStart;
  logic        r_doStop;
  logic        r_doWrite;
  logic        r_doRead;
  logic        r_ackOut;
  logic        r_sclHold;
  logic        r_sdaHold;

  logic        w_busy;
  logic        w_wr;
  logic        w_cmdWr;
  logic        w_bothDir;
  logic        w_accept;
  logic        w_cmdErrSet;
  logic        w_stall;
  logic        w_tick;
  logic        w_sclOe;
  logic        w_sdaOe;
  logic        w_unused;

  assign w_busy      = (r_state != S_IDLE);
  assign w_wr        = chipselect & ~write_n;
  assign w_cmdWr     = w_wr & (address == 2'd1);
  assign w_bothDir   = writedata[2] & writedata[3];
  assign w_accept    = w_cmdWr & ~w_busy & ~w_bothDir & (|writedata[3:0]);
  assign w_cmdErrSet = w_cmdWr & (w_busy | w_bothDir);

  // Clock stretching only applies in quarters where the master has let SCL
  // go; a low pad there means a slave is holding the clock.
`ifdef I2C_CLK_STRETCH_EN
  assign w_stall  = w_busy & ~w_sclOe & ~scl_in;
  assign w_unused = ^writedata[31:16];
`else
  assign w_stall  = 1'b0;
  assign w_unused = ^{writedata[31:16], scl_in};
`endif

  // >= rather than == so that lowering DIV mid-quarter cannot make the
  // counter run all the way round.
  assign w_tick = w_busy & (r_cnt >= r_div) & ~w_stall;

  assign w_afterStart = (r_doWrite | r_doRead) ? S_DATA :
                        (r_doStop ? S_STOP : S_IDLE);
  assign w_afterAck   = r_doStop ? S_STOP : S_IDLE;

  assign scl_oe = w_sclOe;
  assign sda_oe = w_sdaOe;

  // Pad drive as a function of phase and quarter. In IDLE the lines keep
  // whatever the last phase left, so a transfer without STOP keeps the bus.
  always_comb begin
    w_sclOe = r_sclHold;
    w_sdaOe = r_sdaHold;
    case (r_state)
      S_START: begin
        w_sclOe = (r_q == 2'd2);
        w_sdaOe = (r_q != 2'd0);
      end
      S_DATA: begin
        w_sclOe = (r_q == 2'd0) || (r_q == 2'd3);
        w_sdaOe = r_doWrite & ~r_shift[7];
      end
      S_ACK: begin
        w_sclOe = (r_q == 2'd0) || (r_q == 2'd3);
        w_sdaOe = r_doRead & ~r_ackOut;
      end
      S_STOP: begin
        w_sclOe = (r_q == 2'd0);
        w_sdaOe = (r_q != 2'd2);
      end
      default: begin
      end
    endcase
  end

  // Phase sequencing: START, then DATA/ACK, then STOP, skipping phases whose
  // command bit is clear. START and STOP end after q2, DATA and ACK after q3.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (writedata[0])
            w_stateNext = S_START;
          else if (writedata[2] | writedata[3])
            w_stateNext = S_DATA;
          else
            w_stateNext = S_STOP;
        end
      end
      S_START: if (w_tick && r_q == 2'd2) w_stateNext = w_afterStart;
      S_DATA:  if (w_tick && r_q == 2'd3 && r_bit == 3'd7) w_stateNext = S_ACK;
      S_ACK:   if (w_tick && r_q == 2'd3) w_stateNext = w_afterAck;
      S_STOP:  if (w_tick && r_q == 2'd2) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Register reads. Unused bits read as zero; CMD is write-only.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[7:0]  = r_rxByte;
      2'd2:    readdata[2:0]  = {r_cmdErr, r_rxNack, w_busy};
      2'd3:    readdata[15:0] = r_div;
      default: begin
      end
    endcase
  end

  // Host-visible configuration registers. A TXRX write during a transfer
  // only changes tx_byte; the active shifter was loaded at acceptance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_txByte <= '0;
      r_div    <= DIV_DEFAULT;
      r_cmdErr <= 1'b0;
    end else begin
      if (w_wr && address == 2'd0) r_txByte <= writedata[7:0];
      if (w_wr && address == 2'd3) r_div <= writedata[15:0];
      if (w_wr && address == 2'd2)
        r_cmdErr <= 1'b0;
      else if (w_cmdErrSet)
        r_cmdErr <= 1'b1;
    end
  end

  // State register plus the quarter/bit counters and shifters that ride
  // along with it. Reset releases both lines and abandons any transfer
  // without generating a STOP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_q       <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_rxByte  <= '0;
      r_rxNack  <= 1'b0;
      r_doStart <= 1'b0;
      r_doStop  <= 1'b0;
      r_doWrite <= 1'b0;
      r_doRead  <= 1'b0;
      r_ackOut  <= 1'b0;
      r_sclHold <= 1'b0;
      r_sdaHold <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_doStart <= writedata[0];
        r_doStop  <= writedata[1];
        r_doWrite <= writedata[2];
        r_doRead  <= writedata[3];
        r_ackOut  <= writedata[4];
        r_shift   <= r_txByte;
        r_cnt     <= '0;
        r_q       <= '0;
        r_bit     <= '0;
      end else if (w_tick) begin
        r_cnt <= '0;
        r_q   <= (w_stateNext != r_state) ? 2'd0 : r_q + 2'd1;
        if (r_state == S_DATA && r_q == 2'd3) begin
          r_bit   <= r_bit + 3'd1;
          r_shift <= {r_shift[6:0], 1'b0};
        end
        if (r_state == S_DATA && r_q == 2'd2 && r_doRead)
          r_rxByte <= {r_rxByte[6:0], sda_in};
        if (r_state == S_ACK && r_q == 2'd2 && r_doWrite)
          r_rxNack <= sda_in;
        if (w_stateNext == S_IDLE) begin
          r_sclHold <= w_sclOe;
          r_sdaHold <= w_sdaOe;
        end
      end else if (w_busy && !w_stall) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_nios_hps_system_i2c_byte_engine.sv
// tb_nios_hps_system_i2c_byte_engine
//
// Drives the byte engine through its register interface while a small
// behavioural I2C slave watches the pads: it detects START/STOP, records
// the SDA level on every SCL rising edge, ACKs written bytes and supplies
// read data. Expected values come from a transaction-level model of the
// register file and of the transfer length in quarters.
module tb_nios_hps_system_i2c_byte_engine;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        scl_in;
  logic        sda_in;
  logic        scl_oe;
  logic        sda_oe;

  logic        slaveSclLow;
  logic        slaveSdaLow;
  logic        slaveRead;
  logic        slaveAck;
  logic [7:0]  slaveData;

  int          checks;
  int          errors;

  int          startCount;
  int          stopCount;
  int          fallCnt;
  logic        prevScl;
  logic        prevSda;
  logic        sclL;
  logic        sdaL;
  logic        bitQ[$];

  logic [7:0]  expTx;
  logic [7:0]  expRx;
  logic [15:0] expDiv;
  logic        expNack;
  logic        expErr;

  logic [31:0] rd;
  logic [7:0]  rTx;
  logic [7:0]  rCmd;
  logic [15:0] rDiv;

  nios_hps_system_i2c_byte_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe)
  );

  // Open-drain bus: a line is high unless master or slave pulls it low.
  assign scl_in = ~(scl_oe | slaveSclLow);
  assign sda_in = ~(sda_oe | slaveSdaLow);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slave and bus monitor. Falling SCL edges are numbered from
  // the START (or from the bench arming it); after falling edge k the slave
  // presents read bit 7-k, and after edge 8 it answers the ACK slot.
  always @(negedge clk) begin
    sclL = scl_in;
    sdaL = sda_in;
    if (!reset_n) begin
      slaveSdaLow = 1'b0;
    end else begin
      if (prevScl && sclL && prevSda && !sdaL) begin
        startCount++;
        bitQ.delete();
        fallCnt = 0;
      end else if (prevScl && sclL && !prevSda && sdaL) begin
        stopCount++;
      end
      if (!prevScl && sclL) bitQ.push_back(sdaL);
      if (prevScl && !sclL) begin
        if (slaveRead)
          slaveSdaLow = (fallCnt >= 0 && fallCnt < 8) ? ~slaveData[7 - fallCnt] : 1'b0;
        else
          slaveSdaLow = (fallCnt == 8) ? slaveAck : 1'b0;
        fallCnt++;
      end
    end
    prevScl = sclL;
    prevSda = sdaL;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One register write, launched and ended on a falling edge.
  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd2;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
    address = 2'd2;
  endtask

  function automatic logic [8:0] sampled();
    logic [8:0] v;
    v = 'x;
    for (int i = 0; i < 9 && i < bitQ.size(); i++) v[8 - i] = bitQ[i];
    return v;
  endfunction

  // Counts busy cycles one falling edge at a time; optionally issues a CMD
  // write on a chosen busy cycle to exercise the busy-collision path.
  task automatic runTransfer(input int injectAt, input logic [31:0] injCmd,
                             output int busyCycles);
    logic [31:0] st;
    busyCycles = 0;
    for (int g = 0; g < 20000; g++) begin
      readReg(2'd2, st);
      if (!st[0]) break;
      busyCycles++;
      if (busyCycles == injectAt) begin
        address    = 2'd1;
        writedata  = injCmd;
        chipselect = 1'b1;
        write_n    = 1'b0;
      end
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
    end
    readReg(2'd2, st);
    checkOutput("busyTimeout", {31'b0, st[0]}, 32'd0);
  endtask

  // Issue one command and check it against the model: transfer length in
  // quarters, bits seen on the bus, ACK slot, register state and bus lines.
  task automatic doTransfer(input logic [7:0] cmd, input int injectAt,
                            input logic [31:0] injCmd, input int extraCycles);
    int          quarters;
    int          cyc;
    int          s0;
    int          p0;
    logic        isWr;
    logic        isRd;
    logic        eScl;
    logic        eSda;
    logic [8:0]  smp;
    logic [31:0] r;
    isWr = cmd[2];
    isRd = cmd[3];
    quarters = (cmd[0] ? 3 : 0) + ((isWr | isRd) ? 36 : 0) + (cmd[1] ? 3 : 0);
    s0 = startCount;
    p0 = stopCount;
    fallCnt = 0;
    bitQ.delete();
    applyStimulus(2'd1, {24'b0, cmd});
    runTransfer(injectAt, injCmd, cyc);
    if (injectAt > 0) expErr = 1'b1;
    checkOutput("busyCycles", cyc, quarters * (int'(expDiv) + 1) + extraCycles);
    smp = sampled();
    if (isWr) begin
      expNack = ~slaveAck;
      checkOutput("txBits", {24'b0, smp[8:1]}, {24'b0, expTx});
      checkOutput("writeAckSlot", {31'b0, smp[0]}, {31'b0, ~slaveAck});
    end
    if (isRd) begin
      expRx = slaveData;
      checkOutput("readAckSlot", {31'b0, smp[0]}, {31'b0, cmd[4]});
    end
    readReg(2'd0, r);
    checkOutput("rxByte", r, {24'b0, expRx});
    readReg(2'd2, r);
    checkOutput("status", r, {29'b0, expErr, expNack, 1'b0});
    checkOutput("startSeen", startCount - s0, {31'b0, cmd[0]});
    checkOutput("stopSeen", stopCount - p0, {31'b0, cmd[1]});
    if (cmd[1])    begin eScl = 1'b0; eSda = 1'b0;     end
    else if (isWr) begin eScl = 1'b1; eSda = 1'b0;     end
    else if (isRd) begin eScl = 1'b1; eSda = ~cmd[4];  end
    else           begin eScl = 1'b1; eSda = 1'b1;     end
    checkOutput("sclOeAfter", {31'b0, scl_oe}, {31'b0, eScl});
    checkOutput("sdaOeAfter", {31'b0, sda_oe}, {31'b0, eSda});
  endtask

  task automatic resetModel();
    expTx   = 8'h00;
    expRx   = 8'h00;
    expDiv  = 16'd124;
    expNack = 1'b0;
    expErr  = 1'b0;
  endtask

  // Directed sequence followed by randomized transfers.
  initial begin
    checks      = 0;
    errors      = 0;
    startCount  = 0;
    stopCount   = 0;
    fallCnt     = 99;
    prevScl     = 1'b1;
    prevSda     = 1'b1;
    slaveSclLow = 1'b0;
    slaveSdaLow = 1'b0;
    slaveRead   = 1'b0;
    slaveAck    = 1'b1;
    slaveData   = 8'h00;
    address     = 2'd2;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = '0;
    reset_n     = 1'b0;
    resetModel();

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    checkOutput("resetSclOe", {31'b0, scl_oe}, 32'd0);
    checkOutput("resetSdaOe", {31'b0, sda_oe}, 32'd0);
    readReg(2'd2, rd);
    checkOutput("resetStatus", rd, 32'd0);
    readReg(2'd3, rd);
    checkOutput("resetDiv", rd, {16'b0, expDiv});
    readReg(2'd0, rd);
    checkOutput("resetRx", rd, 32'd0);
    @(negedge clk);

    // Reference write: 0xA5 with START and STOP, DIV=3.
    applyStimulus(2'd3, 32'd3);
    expDiv = 16'd3;
    applyStimulus(2'd0, 32'hA5);
    expTx = 8'hA5;
    slaveRead = 1'b0;
    slaveAck  = 1'b1;
    doTransfer(8'h07, 0, 32'h0, 0);

    // Read without START, master NACKs, STOP generated.
    slaveRead = 1'b1;
    slaveData = 8'h3C;
    doTransfer(8'h1A, 0, 32'h0, 0);

    // CMD written while busy: flagged, transfer unchanged.
    slaveRead = 1'b0;
    rTx = 8'($urandom);
    applyStimulus(2'd0, {24'b0, rTx});
    expTx = rTx;
    doTransfer(8'h07, 40, 32'h0000_0007, 0);
    applyStimulus(2'd2, 32'h0);
    expErr = 1'b0;
    readReg(2'd2, rd);
    checkOutput("statusClear1", rd, {29'b0, expErr, expNack, 1'b0});

    // WRITE and READ together is rejected and nothing starts.
    applyStimulus(2'd1, 32'h0C);
    expErr = 1'b1;
    readReg(2'd2, rd);
    checkOutput("bothDirErr", rd, {29'b0, expErr, expNack, 1'b0});
    @(negedge clk);
    readReg(2'd2, rd);
    checkOutput("bothDirIdle", rd, {29'b0, expErr, expNack, 1'b0});
    applyStimulus(2'd2, 32'hFFFF_FFFF);
    expErr = 1'b0;
    readReg(2'd2, rd);
    checkOutput("statusClear2", rd, {29'b0, expErr, expNack, 1'b0});

    // Reset in the middle of data bit 4.
    rTx = 8'($urandom);
    applyStimulus(2'd0, {24'b0, rTx});
    fallCnt = 0;
    bitQ.delete();
    applyStimulus(2'd1, 32'h07);
    repeat (78) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    resetModel();
    checkOutput("midResetScl", {31'b0, scl_oe}, 32'd0);
    checkOutput("midResetSda", {31'b0, sda_oe}, 32'd0);
    readReg(2'd2, rd);
    checkOutput("midResetStatus", rd, 32'd0);
    readReg(2'd3, rd);
    checkOutput("midResetDiv", rd, {16'b0, expDiv});
    reset_n = 1'b1;
    @(negedge clk);

    // New START+WRITE without STOP keeps the bus, then a lone STOP frees it.
    rDiv = 16'($urandom_range(0, 3));
    applyStimulus(2'd3, {16'b0, rDiv});
    expDiv = rDiv;
    rTx = 8'($urandom);
    applyStimulus(2'd0, {24'b0, rTx});
    expTx = rTx;
    slaveAck = 1'b1;
    doTransfer(8'h05, 0, 32'h0, 0);
    doTransfer(8'h02, 0, 32'h0, 0);

    // Randomized full transfers.
    for (int i = 0; i < 6; i++) begin
      rDiv = 16'($urandom_range(0, 3));
      applyStimulus(2'd3, {16'b0, rDiv});
      expDiv = rDiv;
      rTx = 8'($urandom);
      applyStimulus(2'd0, {24'b0, rTx});
      expTx     = rTx;
      slaveAck  = 1'($urandom_range(0, 1));
      slaveData = 8'($urandom);
      slaveRead = 1'($urandom_range(0, 1));
      rCmd = slaveRead ? 8'h0B : 8'h07;
      rCmd[4] = 1'($urandom_range(0, 1));
      doTransfer(rCmd, 0, 32'h0, 0);
    end

`ifdef I2C_CLK_STRETCH_EN
    // Slave holds SCL low for 50 cycles when the master releases it in bit 2.
    applyStimulus(2'd3, 32'd3);
    expDiv = 16'd3;
    rTx = 8'($urandom);
    applyStimulus(2'd0, {24'b0, rTx});
    expTx = rTx;
    slaveRead = 1'b0;
    slaveAck  = 1'b1;
    fork
      doTransfer(8'h07, 0, 32'h0, 50);
      begin : stretchProc
        int   lows;
        logic prevOe;
        lows   = 0;
        prevOe = 1'b0;
        for (int g = 0; g < 2000 && lows < 3; g++) begin
          @(negedge clk);
          if (!prevOe && scl_oe) lows++;
          prevOe = scl_oe;
        end
        slaveSclLow = 1'b1;
        for (int g = 0; g < 200 && scl_oe; g++) @(negedge clk);
        repeat (50) @(negedge clk);
        slaveSclLow = 1'b0;
      end
    join
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
